// File: rtl/loader_pkg.sv
// loader_pkg: shared loader FSM states, byte framing and instruction field positions
package loader_pkg;
  typedef enum logic [2:0] {IDLE, COLLECT, WRITE, DONE, ERROR} loader_state_t;
  localparam int BYTES_PER_INSTR = 3;
  localparam int OP_MSB = 23;
  localparam int OP_LSB = 20;
  localparam int WA_MSB = 19;
  localparam int WA_LSB = 16;
  localparam int RA1_MSB = 15;
  localparam int RA1_LSB = 12;
  localparam int RA2_MSB = 11;
  localparam int RA2_LSB = 8;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;
endpackage

// File: rtl/instr_byte_assembler.sv
// instr_byte_assembler: shifts big-endian stream bytes into one instruction word
// ports: clk, reset (sync active-low), clear (restart framing), accept/in_byte/last (accepted byte),
//        word (assembled bits), word_ready (final byte accepted now), last_early (in_last before final byte)
module instr_byte_assembler
  import loader_pkg::*;
#(
  parameter int INSTR_W = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               accept,
  input  logic               last,
  input  logic [7:0]         in_byte,
  output logic [INSTR_W-1:0] word,
  output logic               word_ready,
  output logic               last_early
);
  logic [1:0] idx;
  logic       final_byte;
  assign final_byte = idx == 2'(BYTES_PER_INSTR - 1);
  assign word_ready = accept && final_byte;
  assign last_early = accept && last && !final_byte;
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      idx  <= '0;
      word <= '0;
    end else if (accept) begin
      idx  <= final_byte ? 2'd0 : idx + 2'd1;
      word <= {word[INSTR_W-9:0], in_byte};
    end
  end
endmodule

// File: rtl/instr_loader.sv
// instr_loader: loads a byte stream into instruction memory and holds the CPU until done
// ports: clk, reset (sync active-low), start, in_valid/in_byte/in_last/in_ready (byte stream),
//        mem_we/mem_addr/mem_wdata (memory write port), word_count, load_done, load_error, cpu_hold
module instr_loader
  import loader_pkg::*;
#(
  parameter int INSTR_W = 24,
  parameter int ADDR_W  = 8,
  parameter int DEPTH   = 256
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               in_valid,
  input  logic [7:0]         in_byte,
  input  logic               in_last,
  output logic               in_ready,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [INSTR_W-1:0] mem_wdata,
  output logic [ADDR_W:0]    word_count,
  output logic               load_done,
  output logic               load_error,
  output logic               cpu_hold
);
  loader_state_t       state, next;
  logic [ADDR_W-1:0]   addr;
  logic [ADDR_W:0]     count;
  logic                last_q, accept, clear, at_top, word_ready, last_early;
  assign accept     = in_valid && in_ready;
  assign clear      = start && (state == IDLE || state == DONE || state == ERROR);
  assign at_top     = addr == ADDR_W'(DEPTH - 1);
  assign in_ready   = state == COLLECT;
  assign mem_we     = state == WRITE;
  assign load_done  = state == DONE;
  assign load_error = state == ERROR;
  assign cpu_hold   = state != DONE;
  assign mem_addr   = addr;
  assign word_count = count;
  instr_byte_assembler #(.INSTR_W(INSTR_W)) u_asm (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .accept    (accept),
    .last      (in_last),
    .in_byte   (in_byte),
    .word      (mem_wdata),
    .word_ready(word_ready),
    .last_early(last_early)
  );
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else state <= next;
  end
  always_comb begin
    next = state;
    next = clear ? COLLECT :
           state == COLLECT ? (last_early ? ERROR : word_ready ? WRITE : COLLECT) :
           state == WRITE ? (last_q ? DONE : at_top ? ERROR : COLLECT) : state;
  end
  // the address saturates at the top word so an overflow never wraps back onto word 0
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      addr   <= '0;
      count  <= '0;
      last_q <= 1'b0;
    end else begin
      if (word_ready) last_q <= in_last;
      if (state == WRITE) begin
        count <= count + 1'b1;
        if (!at_top) addr <= addr + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: randomized directed checks of instr_loader against a word-list model
module tb_instr_loader;
  logic        clk = 0, reset = 0, start = 0, in_valid = 0, in_last = 0;
  logic [7:0]  in_byte = 0;
  logic        in_ready, mem_we, load_done, load_error, cpu_hold;
  logic [7:0]  mem_addr;
  logic [23:0] mem_wdata;
  logic [8:0]  word_count;
  int          total = 0, bad = 0;
  logic [31:0] wq[$];
  logic [7:0]  b[0:773];

  instr_loader dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_byte(in_byte),
    .in_last(in_last), .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .word_count(word_count), .load_done(load_done),
    .load_error(load_error), .cpu_hold(cpu_hold)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (mem_we === 1'b1) wq.push_back({mem_addr, mem_wdata});

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_hold"}, 32'(cpu_hold), 1);
    check({tag, "_ready"}, 32'(in_ready), 0);
    check({tag, "_we"}, 32'(mem_we), 0);
    check({tag, "_addr"}, 32'(mem_addr), 0);
    check({tag, "_wdata"}, 32'(mem_wdata), 0);
    check({tag, "_count"}, 32'(word_count), 0);
    check({tag, "_done"}, 32'(load_done), 0);
    check({tag, "_err"}, 32'(load_error), 0);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
  endtask

  task automatic send(input logic [7:0] v, input bit last, input bit gap);
    bit ok = 0;
    if (gap) repeat ($urandom_range(0, 2)) @(negedge clk);
    in_valid = 1; in_byte = v; in_last = last;
    for (int i = 0; i < 20 && !ok; i++) begin
      ok = in_ready;
      @(negedge clk);
    end
    in_valid = 0; in_last = 0;
    check("send_accept", 32'(ok), 1);
  endtask

  task automatic load(input int n, input bit with_last, input bit gap);
    for (int i = 0; i < 3 * n; i++) begin
      b[i] = 8'($urandom);
      send(b[i], with_last && i == 3 * n - 1, gap);
    end
  endtask

  task automatic wait_end();
    for (int i = 0; i < 20 && !(load_done || load_error); i++) @(negedge clk);
    check("end_flag", 32'(load_done || load_error), 1);
  endtask

  task automatic expect_writes(input int n, input string tag);
    check({tag, "_nwr"}, 32'(wq.size()), 32'(n));
    for (int i = 0; i < n && i < wq.size(); i++)
      check(tag, wq[i], {8'(i), b[3*i], b[3*i+1], b[3*i+2]});
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_reset("reset");
    reset = 1;
    // single word
    pulse_start();
    b[0] = 8'h1A; b[1] = 8'h23; b[2] = 8'h05;
    send(b[0], 0, 0); send(b[1], 0, 0); send(b[2], 1, 0);
    check("w1_we", 32'(mem_we), 1);
    check("w1_addr", 32'(mem_addr), 0);
    check("w1_data", 32'(mem_wdata), 32'h1A2305);
    @(negedge clk);
    check("w1_done", 32'(load_done), 1);
    check("w1_hold", 32'(cpu_hold), 0);
    check("w1_count", 32'(word_count), 1);
    expect_writes(1, "w1");
    // four words with gaps, restarted from DONE
    wq.delete();
    pulse_start();
    load(4, 1, 1);
    wait_end();
    check("w4_done", 32'(load_done), 1);
    check("w4_count", 32'(word_count), 4);
    expect_writes(4, "w4");
    // early in_last
    wq.delete();
    pulse_start();
    send(8'($urandom), 0, 0);
    send(8'($urandom), 1, 0);
    check("early_err", 32'(load_error), 1);
    check("early_hold", 32'(cpu_hold), 1);
    check("early_ready", 32'(in_ready), 0);
    @(negedge clk);
    check("early_nwr", 32'(wq.size()), 0);
    pulse_start();
    load(1, 1, 1);
    wait_end();
    check("recover_done", 32'(load_done), 1);
    check("recover_count", 32'(word_count), 1);
    expect_writes(1, "recover");
    // overflow: 256 words fill memory, the 257th is refused
    wq.delete();
    pulse_start();
    load(256, 0, 0);
    wait_end();
    check("ovf_err", 32'(load_error), 1);
    check("ovf_done", 32'(load_done), 0);
    check("ovf_count", 32'(word_count), 256);
    expect_writes(256, "ovf");
    in_valid = 1; in_byte = 8'($urandom);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("ovf_ready", 32'(in_ready), 0);
    end
    in_valid = 0;
    check("ovf_nwr_after", 32'(wq.size()), 256);
    // reset mid-load after one word plus two bytes
    wq.delete();
    pulse_start();
    load(1, 0, 1);
    send(8'($urandom), 0, 0);
    send(8'($urandom), 0, 0);
    reset = 0;
    @(negedge clk);
    check_reset("midrst");
    reset = 1;
    wq.delete();
    pulse_start();
    load(1, 1, 0);
    wait_end();
    check("post_done", 32'(load_done), 1);
    check("post_count", 32'(word_count), 1);
    expect_writes(1, "post");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instr_loader.md
# instr_loader

Writes a program into the 24-bit instruction memory before the CPU runs. Takes a byte stream over a valid/ready handshake and assembles each group of three bytes into one instruction word. Writes each word through the memory's write port at consecutive addresses. Holds the CPU in reset until the load completes cleanly.

## Interface
- `INSTR_W`, 24, instruction width (op[23:20], WA[19:16], RA1[15:12], RA2[11:8], imm[7:0])
- `ADDR_W`, 8, instruction memory address width
- `DEPTH`, 256, number of words; must be ≤ 2^ADDR_W

Ports:
- `clk` input 1: the only clock.
- `reset` input 1: synchronous, active-low.
- `start` input 1: one-cycle pulse that begins a load.
- `in_valid` input 1: `in_byte` is valid.
- `in_byte` input 8: stream byte.
- `in_last` input 1: marks the final byte of the program; qualified by `in_valid`.
- `in_ready` output 1: the loader accepts a byte this cycle.
- `mem_we` output 1: instruction memory write enable.
- `mem_addr` output ADDR_W: write address.
- `mem_wdata` output INSTR_W: write data.
- `word_count` output ADDR_W+1: number of words written in the current load.
- `load_done` output 1: the program loaded without error.
- `load_error` output 1: the load was aborted.
- `cpu_hold` output 1: active-high hold/reset to the CPU core.

## Operation
- States: IDLE, COLLECT, WRITE, DONE, ERROR.
- IDLE:
  - `cpu_hold`=1, `in_ready`=0.
  - `start` → COLLECT; clears the address, `word_count`, the byte index, and both flags.
- COLLECT:
  - `in_ready`=1. A byte is accepted when `in_valid && in_ready`.
  - Byte order is big-endian: byte 0 → [23:16], byte 1 → [15:8], byte 2 → [7:0]. The byte index counts 0..2.
  - `in_last` accepted at index 0 or 1 → ERROR; no write occurs.
  - Accepting byte 2 → WRITE, latching whether that byte carried `in_last`.
- WRITE:
  - Lasts one cycle: `mem_we`=1, `mem_addr`=current address, `mem_wdata`=assembled word.
  - After the write, the address and `word_count` increment.
  - Next state:
    - latched `in_last` → DONE;
    - otherwise, address was DEPTH-1 → ERROR (overflow);
    - otherwise → COLLECT.
- DONE: `load_done`=1, `cpu_hold`=0, `in_ready`=0.
- ERROR: `load_error`=1, `cpu_hold`=1, `in_ready`=0.
- From DONE or ERROR, `start` → COLLECT, and the load restarts at address 0.
- `start` is ignored in COLLECT and WRITE.
- `in_valid` without `in_ready` is not consumed; the upstream holds the byte.
- Memory contents are never cleared by this block. Only addresses 0..`word_count`-1 are defined after a load.

## Timing
- Reset (`reset`=0 at a clock edge):
  - state IDLE;
  - `mem_we`=0, `mem_addr`=0, `mem_wdata`=0;
  - `word_count`=0, `load_done`=0, `load_error`=0;
  - `cpu_hold`=1, `in_ready`=0.
- Reset mid-load abandons the partial word and returns to IDLE on the next edge. Words already written remain in memory.
- All outputs are registered or decoded from registered state only. `in_ready` is decoded from state and does not depend on `in_valid`.
- `mem_we` asserts in the cycle after the edge that accepted byte 2, for exactly one cycle.
- Peak throughput is 4 cycles per word (3 accepts + 1 write).
- `load_done` or `load_error` rises in the cycle after the final WRITE or the offending accept.
- `cpu_hold` falls in the same cycle that `load_done` rises.
- `word_count` updates in the cycle after WRITE. Its range is 0..DEPTH, so its width is ADDR_W+1 and it never wraps.
- The address is ADDR_W wide. It reaches DEPTH-1 at most, and overflow is caught before any wrap.

## Structure
- Package `loader_pkg`:
  - state enum `loader_state_t`;
  - `BYTES_PER_INSTR`=3;
  - instruction field MSB/LSB constants (OP, WA, RA1, RA2, IMM), shared with the CPU decode.
- One sub-module, `instr_byte_assembler`:
  - a 2-bit byte index plus a 24-bit shift/load register;
  - signals `word_ready`, and `last_early` when `in_last` arrives before byte 2;
  - cleared by the loader on `start` and on reset.
- The top level holds the FSM, the address counter, `word_count`, and the output registers.

## Test plan
- Reset held low for 2 cycles:
  - `cpu_hold`=1, `in_ready`=0, `mem_we`=0;
  - `word_count`=0, `load_done`=0, `load_error`=0.
- `start`, then bytes 0x1A, 0x23, 0x05, with `in_last` on 0x05:
  - one `mem_we` pulse with addr 0 and data 0x1A2305;
  - next cycle `load_done`=1, `cpu_hold`=0, `word_count`=1.
- Four words sent with random `in_valid` gaps and `in_last` on byte 12:
  - writes land at addresses 0..3 with the correct data;
  - no byte is dropped or duplicated;
  - final `word_count`=4.
- `in_last` on the second byte of word 0:
  - no `mem_we`;
  - `load_error`=1, `cpu_hold`=1;
  - a later `start` plus a valid 1-word program → `load_done`=1.
- 257 words with no `in_last` (DEPTH=256):
  - 256 writes, addresses 0..255;
  - `load_error`=1 after the write to address 255;
  - `in_ready`=0 from then on;
  - `word_count`=256.
- `reset` driven low after 1 word plus 2 bytes:
  - the next edge gives IDLE with all reset values;
  - `start` plus 1 word → written at address 0, `word_count`=1.
